spike_router_csr: RTL and testbench

- Parametrised, fully synchronous successor to the combinational spike fan-out stage.
- Accepts one N-bit spike vector per timestep and walks a CSR connection table (per-neuron pointers into a downstream-address array).
- Emits one {source address, destination address} packet per connection over a valid/ready stream with backpressure.
- Sits between the neuron-core spike outputs and the accumulator/NoC injection port. Tables are loaded through a register-style config write port, not wide parallel buses.

---
 rtl/spike_router_csr.sv | 142 ++++++++++++++
 tb/tb_spike_router_csr.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/spike_router_csr.sv
// spike_router_csr: walks a CSR connection table for each spike vector and
// streams {source, destination} address packets with valid/ready backpressure.
module spike_router_csr #(
    parameter int N_NEURONS = 10,
    parameter int ADDR_W    = 12,
    parameter int MAX_CONN  = 32,
    parameter int PTR_W     = 6
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [PTR_W-1:0]       cfg_idx,
    input  logic [ADDR_W-1:0]      cfg_data,
    input  logic                   spike_valid,
    output logic                   spike_ready,
    input  logic [N_NEURONS-1:0]   spikes,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [2*ADDR_W-1:0]    pkt,
    output logic                   busy,
    output logic                   ts_done,
    output logic [PTR_W:0]         ts_pkt_count
);
    localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int PW = $clog2(N_NEURONS + 1);
    localparam int CW = (MAX_CONN > 1) ? $clog2(MAX_CONN) : 1;
    localparam logic [PTR_W-1:0] N_P = PTR_W'(N_NEURONS);
    localparam logic [PTR_W-1:0] M_P = PTR_W'(MAX_CONN);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DRAIN} state_t;

    logic [ADDR_W-1:0] naddr_q [N_NEURONS];
    logic [PTR_W-1:0]  ptr_q   [N_NEURONS+1];
    logic [ADDR_W-1:0] conn_q  [MAX_CONN];

    state_t                state_q, state_d;
    logic [N_NEURONS-1:0]  pending_q, pending_d;
    logic [NW-1:0]         idx_q, idx_d, sel;
    logic [PTR_W-1:0]      j_q, j_d, end_q, end_d, ptr_hi;
    logic [PTR_W:0]        cnt_q, cnt_d, ts_cnt_q, ts_cnt_d;
    logic [2*ADDR_W-1:0]   pkt_q, pkt_d;
    logic                  pkt_valid_q, pkt_valid_d, ts_done_q, ts_done_d;
    logic                  out_free, load, cfg_ok;

    assign cfg_ok       = cfg_we && state_q == IDLE;
    assign spike_ready  = state_q == IDLE;
    assign busy         = state_q != IDLE;
    assign pkt_valid    = pkt_valid_q;
    assign pkt          = pkt_q;
    assign ts_done      = ts_done_q;
    assign ts_pkt_count = ts_cnt_q;

    // Tables hold their contents across RESET; only idle-time writes land.
    always_ff @(posedge CLK) begin
        if (cfg_ok && cfg_sel == 2'd0 && cfg_idx < N_P)
            naddr_q[cfg_idx[NW-1:0]] <= cfg_data;
        if (cfg_ok && cfg_sel == 2'd1 && cfg_idx <= N_P)
            ptr_q[cfg_idx[PW-1:0]] <= cfg_data[PTR_W-1:0];
        if (cfg_ok && cfg_sel == 2'd2 && cfg_idx < M_P)
            conn_q[cfg_idx[CW-1:0]] <= cfg_data;
    end

    always_comb begin
        sel = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--)
            if (pending_q[i]) sel = NW'(i);
        ptr_hi = ptr_q[PW'(sel) + PW'(1)];
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        j_d       = j_q;
        end_d     = end_q;
        cnt_d     = cnt_q;
        pkt_d     = pkt_q;
        ts_cnt_d  = ts_cnt_q;
        ts_done_d = 1'b0;
        load      = 1'b0;
        out_free  = !pkt_valid_q || pkt_ready;
        case (state_q)
            IDLE: if (spike_valid) begin
                pending_d = spikes;
                cnt_d     = '0;
                state_d   = SCAN;
            end
            SCAN: if (|pending_q) begin
                idx_d          = sel;
                j_d            = ptr_q[PW'(sel)];
                end_d          = (ptr_hi > M_P) ? M_P : ptr_hi;
                pending_d[sel] = 1'b0;
                state_d        = EMIT;
            end else begin
                state_d = DRAIN;
            end
            EMIT: if (j_q >= end_q) begin
                state_d = SCAN;
            end else if (out_free) begin
                load    = 1'b1;
                pkt_d   = {naddr_q[idx_q], conn_q[j_q[CW-1:0]]};
                j_d     = j_q + 1'b1;
                cnt_d   = cnt_q + {{PTR_W{1'b0}}, ~&cnt_q};
                state_d = (j_d == end_q) ? SCAN : EMIT;
            end
            DRAIN: if (out_free) begin
                ts_done_d = 1'b1;
                ts_cnt_d  = cnt_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pkt_valid_d = load || (pkt_valid_q && !pkt_ready);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            idx_q       <= '0;
            j_q         <= '0;
            end_q       <= '0;
            cnt_q       <= '0;
            pkt_q       <= '0;
            pkt_valid_q <= 1'b0;
            ts_done_q   <= 1'b0;
            ts_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            j_q         <= j_d;
            end_q       <= end_d;
            cnt_q       <= cnt_d;
            pkt_q       <= pkt_d;
            pkt_valid_q <= pkt_valid_d;
            ts_done_q   <= ts_done_d;
            ts_cnt_q    <= ts_cnt_d;
        end
    end
endmodule

// File: tb/tb_spike_router_csr.sv
// tb_spike_router_csr: randomized bench comparing the router against a
// list-building reference model of the CSR fan-out.
module tb_spike_router_csr;
    localparam int N  = 10;
    localparam int AW = 12;
    localparam int MC = 32;
    localparam int PW = 6;

    logic            CLK = 1'b0, RESET = 1'b1;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_sel = '0;
    logic [PW-1:0]   cfg_idx = '0;
    logic [AW-1:0]   cfg_data = '0;
    logic            spike_valid = 1'b0, spike_ready;
    logic [N-1:0]    spikes = '0;
    logic            pkt_valid, pkt_ready = 1'b1;
    logic [2*AW-1:0] pkt;
    logic            busy, ts_done;
    logic [PW:0]     ts_pkt_count;

    int n_chk = 0, n_fail = 0;
    logic [AW-1:0]   m_naddr [N];
    int              m_ptr   [N+1];
    logic [AW-1:0]   m_conn  [MC];
    int              first_c;
    logic [2*AW-1:0] first_pkt;

    spike_router_csr #(.N_NEURONS(N), .ADDR_W(AW), .MAX_CONN(MC), .PTR_W(PW)) dut (
        .CLK(CLK), .RESET(RESET), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .spike_valid(spike_valid), .spike_ready(spike_ready),
        .spikes(spikes), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt(pkt),
        .busy(busy), .ts_done(ts_done), .ts_pkt_count(ts_pkt_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int sel, input int idx, input int data);
        @(negedge CLK);
        cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_idx = PW'(idx); cfg_data = AW'(data);
        @(negedge CLK);
        cfg_we = 1'b0;
        if (sel == 0 && idx < N)  m_naddr[idx] = AW'(data);
        if (sel == 1 && idx <= N) m_ptr[idx]   = data % (1 << PW);
        if (sel == 2 && idx < MC) m_conn[idx]  = AW'(data);
    endtask

    // mode: 0 always ready, 1 stall 3 cycles at first valid, 2 random ready
    task automatic run_ts(input logic [N-1:0] sp, input int mode, input int abort_after,
                          input bit interlock, input int exp_edges);
        logic [2*AW-1:0] q[$];
        logic [2*AW-1:0] prev_pkt;
        int got = 0, stalls = 0, e;
        bit done = 0, prev_hold = 0;
        for (int i = 0; i < N; i++)
            if (sp[i]) begin
                e = (m_ptr[i+1] > MC) ? MC : m_ptr[i+1];
                for (int j = m_ptr[i]; j < e; j++) q.push_back({m_naddr[i], m_conn[j]});
            end
        first_c = 0; first_pkt = '0;
        @(negedge CLK);
        check("spike_ready_idle", spike_ready, 1);
        spike_valid = 1'b1; spikes = sp;
        @(negedge CLK);
        spike_valid = 1'b0;
        for (int c = 1; c < 2000 && !done; c++) begin
            if (mode == 0) pkt_ready = 1'b1;
            else if (mode == 1) begin
                pkt_ready = !(pkt_valid && stalls < 3);
                if (!pkt_ready) stalls++;
            end else pkt_ready = 1'($urandom_range(0, 1));
            if (prev_hold) check("pkt_stable", {pkt_valid, pkt}, {1'b1, prev_pkt});
            if (pkt_valid && first_c == 0) begin first_c = c; first_pkt = pkt; end
            if (pkt_valid && pkt_ready) begin
                if (got < q.size()) check("pkt_seq", pkt, q[got]);
                else check("pkt_extra", got, q.size() - 1);
                got++;
            end
            prev_hold = pkt_valid && !pkt_ready;
            prev_pkt  = pkt;
            if (interlock && c == 3) begin
                check("ready_busy", {busy, spike_ready}, 2'b10);
                cfg_we = 1'b1; cfg_sel = 2'd2; cfg_idx = '0; cfg_data = 12'hFFF;
                spike_valid = 1'b1; spikes = N'(1);
            end else begin
                cfg_we = 1'b0; spike_valid = 1'b0;
            end
            if (ts_done) begin
                done = 1;
                check("pkt_total", got, q.size());
                check("ts_pkt_count", ts_pkt_count, (q.size() > 127) ? 127 : q.size());
                if (exp_edges >= 0) check("done_latency", c - 1, exp_edges);
            end
            if (abort_after > 0 && got == abort_after) begin
                RESET = 1'b1;
                @(negedge CLK);
                RESET = 1'b0;
                check("abort_state", {pkt_valid, busy, spike_ready, ts_done}, 4'b0010);
                return;
            end
            if (!done) @(negedge CLK);
        end
        if (!done) check("ts_done_timeout", 0, 1);
        pkt_ready = 1'b1;
        @(negedge CLK);
        check("ts_done_pulse", ts_done, 0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_outs", {spike_ready, pkt_valid, busy, ts_done}, 4'b1000);
        check("rst_pkt", pkt, 0);
        check("rst_count", ts_pkt_count, 0);
        RESET = 1'b0;
        for (int i = 0; i < N; i++) cfg_write(0, i, (i < 4) ? 'h100 + i : $urandom_range(0, 4095));
        for (int i = 0; i <= N; i++) cfg_write(1, i, (i == 0) ? 0 : (i < 3) ? 2 : (i == 3) ? 3 : 5);
        for (int i = 0; i < MC; i++) cfg_write(2, i, $urandom_range(0, 4095));
        cfg_write(2, 0, 'hA00); cfg_write(2, 1, 'hA01); cfg_write(2, 2, 'hB00);
        cfg_write(2, 3, 'hC00); cfg_write(2, 4, 'hC01);
        cfg_write(0, 16, 'h777); cfg_write(1, 16, 9); cfg_write(2, 32, 'h777);

        run_ts(N'(4'b1011), 0, 0, 0, -1);
        check("first_latency", first_c, 3);
        check("first_pkt", first_pkt, 24'h100A00);
        run_ts(N'(4'b1011), 1, 0, 0, -1);
        run_ts('0, 0, 0, 0, 2);
        check("zero_no_valid", first_c, 0);
        run_ts(N'(4'b1011), 0, 0, 1, -1);
        run_ts(N'(4'b0001), 0, 0, 0, -1);
        check("interlock_pkt", first_pkt, 24'h100A00);
        run_ts(N'(4'b1011), 0, 2, 0, -1);
        run_ts(N'(4'b1011), 2, 0, 0, -1);

        cfg_write(1, 3, 4); cfg_write(1, 4, 2);
        run_ts(N'(4'b1000), 0, 0, 0, -1);
        check("inverted_empty", first_c, 0);
        cfg_write(1, 8, 28); cfg_write(1, 9, 40);
        run_ts(N'(10'b01_0000_0000), 2, 0, 0, -1);

        for (int i = 0; i <= N; i++) cfg_write(1, i, (i % 2) ? 63 : 0);
        run_ts('1, 2, 0, 0, -1);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i <= N; i++) cfg_write(1, i, $urandom_range(0, 40));
            for (int k = 0; k < 4; k++) cfg_write($urandom_range(0, 3), $urandom_range(0, 40), $urandom_range(0, 4095));
            run_ts(N'($urandom), 2, 0, 0, -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
